// File: rtl/clb_bist.sv
// Self-test initiator for the CLB: walks all 16 {mode,A,B} vectors over the pads,
// samples the fed-back Y after SETTLE_CYCLES extra cycles per vector, and reports pass/fail, error count and first failure.
module clb_bist #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [16:0] ui_PAD2CORE,
    output logic [16:0] uo_CORE2PAD
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_cnt_q, err_cnt_d;
    logic [3:0] first_fail_q, first_fail_d;
    logic       fail_seen_q, fail_seen_d;
    logic       pass_q, pass_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic [3:0] stim_q, stim_d;

    logic start, y_in, abort;
    logic exp_y;
    logic unused_pad;

    assign start      = ui_PAD2CORE[0];
    assign y_in       = ui_PAD2CORE[1];
    assign abort      = ui_PAD2CORE[2];
    assign unused_pad = ^ui_PAD2CORE[16:3];

    // Golden truth table for the vector currently on the pads.
    always_comb begin
        exp_y = 1'b0;
        case (idx_q[3:2])
            2'b00:   exp_y = idx_q[1] & idx_q[0];
            2'b01:   exp_y = idx_q[1] | idx_q[0];
            2'b10:   exp_y = idx_q[1] ^ idx_q[0];
            default: exp_y = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        pass_d       = pass_q;
        done_d       = done_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d      = RUN;
                    idx_d        = 4'd0;
                    cnt_d        = SETTLE_LD;
                    err_cnt_d    = 5'd0;
                    first_fail_d = 4'd0;
                    fail_seen_d  = 1'b0;
                    pass_d       = 1'b0;
                    done_d       = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (y_in != exp_y) begin
                        err_cnt_d = err_cnt_q + 5'd1;
                        if (!fail_seen_q) begin
                            first_fail_d = idx_q;
                            fail_seen_d  = 1'b1;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == 5'd0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = SETTLE_LD;
                    end
                end
            end
            DONE: begin
                // Require start to drop first so a held start cannot retrigger.
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pad stimulus is registered from the next-state index: {mode, B, A}.
        busy_d = (state_d == RUN);
        stim_d = busy_d ? {idx_d[3:2], idx_d[0], idx_d[1]} : 4'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            cnt_q        <= 4'd0;
            err_cnt_q    <= 5'd0;
            first_fail_q <= 4'd0;
            fail_seen_q  <= 1'b0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            stim_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            stim_q       <= stim_d;
        end
    end

    assign uo_CORE2PAD = {fail_seen_q, first_fail_q, err_cnt_q, pass_q, done_q, busy_q, stim_q};

endmodule

// File: tb/tb_clb_bist.sv
// Directed bench for clb_bist: a CLB model (golden or faulty) closes the Y loop from the stimulus pads.
module tb_clb_bist;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] pad_hi = 14'd0;
    logic        y_in;
    logic [16:0] ui_PAD2CORE;
    logic [16:0] uo_CORE2PAD;

    int errors = 0;
    int checks = 0;
    int fault  = 0;   // 0 golden, 1 stuck-0, 2 stuck-1, 3 mode-10 rows inverted

    always #5 clk_i = ~clk_i;

    assign ui_PAD2CORE = {pad_hi, abort, y_in, start};

    clb_bist #(.SETTLE_CYCLES(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ui_PAD2CORE (ui_PAD2CORE),
        .uo_CORE2PAD (uo_CORE2PAD)
    );

    wire       a      = uo_CORE2PAD[0];
    wire       b      = uo_CORE2PAD[1];
    wire [1:0] mode   = uo_CORE2PAD[3:2];
    wire       busy   = uo_CORE2PAD[4];
    wire       done   = uo_CORE2PAD[5];
    wire       pass   = uo_CORE2PAD[6];
    wire [4:0] errc   = uo_CORE2PAD[11:7];
    wire [3:0] ffidx  = uo_CORE2PAD[15:12];
    wire       fseen  = uo_CORE2PAD[16];

    // CLB model driven from the stimulus pads.
    always_comb begin
        logic g;
        case (mode)
            2'b00:   g = a & b;
            2'b01:   g = a | b;
            2'b10:   g = a ^ b;
            default: g = 1'b0;
        endcase
        case (fault)
            1:       y_in = 1'b0;
            2:       y_in = 1'b1;
            3:       y_in = (mode == 2'b10) ? ~g : g;
            default: y_in = g;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_run(input int f, input bit hold);
        fault = f;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
    endtask

    // Counts busy cycles with a bound; optionally checks the pad stimulus order.
    task automatic wait_done(input bit chk_stim);
        int c;
        logic [3:0] k;
        c = 0;
        while (busy && c < 200) begin
            if (chk_stim) begin
                k = 4'(c / 3);
                chk("stim", {28'd0, uo_CORE2PAD[3:0]}, {28'd0, k[3:2], k[0], k[1]});
            end
            c++;
            step();
        end
        chk("busy_cycles", c, 48);
    endtask

    initial begin
        // Reset
        #12;
        chk("reset_uo", uo_CORE2PAD, 17'd0);
        rst_i = 1'b0;
        step();
        chk("idle_uo", uo_CORE2PAD, 17'd0);

        // Golden run, ignored pad bits driven high
        pad_hi = 14'h3fff;
        start_run(0, 1'b0);
        chk("first_busy", busy, 1'b1);
        chk("first_stim", {28'd0, uo_CORE2PAD[3:0]}, 32'd0);
        wait_done(1'b0);
        chk("gold_done", done, 1'b1);
        chk("gold_pass", pass, 1'b1);
        chk("gold_err", errc, 5'd0);
        chk("gold_fseen", fseen, 1'b0);
        chk("gold_stim0", {28'd0, uo_CORE2PAD[3:0]}, 32'd0);
        pad_hi = 14'd0;
        step();

        // Stuck-at-0 Y
        start_run(1, 1'b0);
        wait_done(1'b0);
        chk("s0_err", errc, 5'd6);
        chk("s0_ffidx", ffidx, 4'd3);
        chk("s0_fseen", fseen, 1'b1);
        chk("s0_pass", pass, 1'b0);
        chk("s0_done", done, 1'b1);
        step();

        // Stuck-at-1 Y with start held across DONE
        start_run(2, 1'b1);
        wait_done(1'b0);
        chk("s1_err", errc, 5'd10);
        chk("s1_ffidx", ffidx, 4'd0);
        chk("s1_pass", pass, 1'b0);
        repeat (3) step();
        chk("held_busy", busy, 1'b0);
        chk("held_done", done, 1'b1);
        start = 1'b0;
        step();
        chk("rel_busy", busy, 1'b0);
        chk("rel_done", done, 1'b1);
        chk("rel_err", errc, 5'd10);

        // Second run clears results; mode-10 rows inverted, stimulus order checked
        start_run(3, 1'b0);
        chk("clr_err", errc, 5'd0);
        chk("clr_done", done, 1'b0);
        chk("clr_fseen", fseen, 1'b0);
        wait_done(1'b1);
        chk("inv_err", errc, 5'd4);
        chk("inv_ffidx", ffidx, 4'd8);
        chk("inv_pass", pass, 1'b0);
        step();

        // abort and start together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        chk("abort_idle_busy", busy, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        step();

        // Abort during busy cycle 20 (vector 6)
        start_run(1, 1'b0);
        repeat (19) step();
        chk("pre_abort_busy", busy, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_pass", pass, 1'b0);
        chk("abort_stim", {28'd0, uo_CORE2PAD[3:0]}, 32'd0);
        chk("abort_err", errc, 5'd2);
        chk("abort_ffidx", ffidx, 4'd3);
        step();
        chk("abort_stays_idle", busy, 1'b0);

        // Asynchronous reset mid-run
        start_run(2, 1'b0);
        repeat (10) step();
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_uo", uo_CORE2PAD, 17'd0);
        #1 rst_i = 1'b0;
        step();
        chk("post_rst_uo", uo_CORE2PAD, 17'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clb_bist.md
Name: clb_bist

Overview:
- Built-in self-test initiator for the configurable logic block (LUT with AND/OR/XOR/zero modes).
- Drives the block's A, B and mode pad inputs through all 16 vectors and samples its Y output fed back on a pad.
- Compares each sample against the golden truth table and reports pass/fail, error count and the first failing vector.
- Sits in the wrapper's user area behind the same 17-bit pad interface, as the stimulus/check end of the CLB's pad protocol.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each vector is held before Y is sampled; legal range 0..15.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- ui_PAD2CORE  input  17  [0]=start, [1]=y_in (CLB Y), [2]=abort, [16:3] ignored.
- uo_CORE2PAD  output  17  [0]=A, [1]=B, [3:2]=mode, [4]=busy, [5]=done, [6]=pass, [11:7]=err_cnt, [15:12]=first_fail_idx, [16]=fail_seen.

Behaviour:
- One clock domain; y_in is sampled directly with no synchronizer. All outputs are registered.
- Reset (async assert, sync release): state=IDLE; every uo bit is 0.
- Vector index idx[3:0]: mode=idx[3:2], A=idx[1], B=idx[0]; vectors are applied in order 0..15.
- Expected Y by mode:
  - mode 00: A&B
  - mode 01: A|B
  - mode 10: A^B
  - mode 11: 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - A/B/mode=0, busy=0.
  - start=1 at a clock edge -> RUN with idx=0, settle counter=SETTLE_CYCLES.
  - Same edge clears err_cnt, first_fail_idx, fail_seen, pass, done; sets busy=1.
- RUN:
  - A/B/mode show idx from the first RUN cycle.
  - Each vector is held exactly SETTLE_CYCLES+1 cycles.
  - Counter decrements each cycle. At the edge where the counter is 0, y_in is compared with expected.
  - On mismatch: err_cnt+=1; if fail_seen=0, first_fail_idx=idx and fail_seen=1.
  - Then idx+=1 and counter reloads. At idx=15 the state goes to DONE instead of wrapping.
- Run length: 16*(SETTLE_CYCLES+1) cycles with busy=1; 48 cycles at default.
- DONE:
  - busy=0, done=1, pass=(err_cnt==0), A/B/mode=0. Results hold.
  - Leaves for IDLE only when start=0, so a held start never retriggers.
  - done stays 1 in IDLE until the next run starts.
- err_cnt is 5 bits, max 16, no overflow possible.
- abort=1 in RUN: next edge goes to IDLE; busy=0, done=0, pass=0, stimulus=0. err_cnt and fail fields keep partial values.
- abort is ignored in IDLE/DONE.
- abort and start both high in IDLE: abort wins, no run starts.
- Reset mid-run: immediate return to all-zero outputs, IDLE.
- ui_PAD2CORE[16:3] have no effect.

Test Plan:
- Reset, start=1 for 1 cycle, y_in looped through golden CLB model (SETTLE_CYCLES=2) -> busy=1 for exactly 48 cycles; done=1, pass=1, err_cnt=0, fail_seen=0.
- y_in stuck 0 -> err_cnt=6, first_fail_idx=3 (mode 00, A=B=1), fail_seen=1, pass=0.
- y_in stuck 1 -> err_cnt=10, first_fail_idx=0, pass=0.
- Golden model with mode 10 row inverted -> err_cnt=4, first_fail_idx=8. Also check the stimulus sequence: mode/A/B change every 3 cycles in index order.
- start held high across DONE, then released, then pulsed again -> no second run until start has returned low; second run clears counters.
- abort at cycle 20 of a run -> next cycle busy=0, done=0, A/B/mode=0. Separately, rst_i pulse mid-run -> all uo bits 0 immediately, asynchronously.
